// File: rtl/l2_port_arbiter.sv
// Round-robin owner of the shared L2 line-fill port for the I-cache and
// D-cache miss paths; one outstanding transaction, with timeout and stats.
module l2_port_arbiter #(
   parameter int ADDR_W  = 26,
   parameter int CNT_W   = 32,
   parameter int TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_req,
   input  logic [ADDR_W-1:0] i_addr,
   output logic              i_ack,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   output logic              d_ack,
   output logic              err,
   output logic              l2_valid,
   output logic              l2_we,
   output logic [ADDR_W-1:0] l2_addr,
   output logic              l2_src,
   input  logic              l2_ready,
   input  logic              l2_done,
   output logic [CNT_W-1:0]  i_grants,
   output logic [CNT_W-1:0]  d_grants,
   output logic [CNT_W-1:0]  busy_cycles,
   output logic [CNT_W-1:0]  timeouts
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   localparam logic [15:0]      T_LAST = 16'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0] C_MAX  = '1;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              we_q, we_d;
   logic              src_q, src_d;
   logic              last_q, last_d;
   logic              mask_q, mask_d;
   logic              err_q, err_d;
   logic [15:0]       timer_q, timer_d;
   logic [CNT_W-1:0]  ig_q, ig_d;
   logic [CNT_W-1:0]  dg_q, dg_d;
   logic [CNT_W-1:0]  busy_q, busy_d;
   logic [CNT_W-1:0]  to_q, to_d;

   logic eff_i, eff_d, g_src;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == C_MAX) ? v : v + CNT_W'(1);
   endfunction

   // The just-served requester is ignored for one IDLE cycle after RESP
   assign eff_i = i_req & ~(mask_q & ~last_q);
   assign eff_d = d_req & ~(mask_q &  last_q);
   assign g_src = (eff_i & eff_d) ? ~last_q : eff_d;

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      we_d    = we_q;
      src_d   = src_q;
      last_d  = last_q;
      mask_d  = mask_q;
      err_d   = err_q;
      timer_d = timer_q;
      ig_d    = ig_q;
      dg_d    = dg_q;
      busy_d  = busy_q;
      to_d    = to_q;
      if (state_q != IDLE) busy_d = sat_inc(busy_q);
      unique case (state_q)
         IDLE: begin
            mask_d = 1'b0;
            if (eff_i | eff_d) begin
               src_d   = g_src;
               addr_d  = g_src ? d_addr : i_addr;
               we_d    = g_src & d_we;
               state_d = ISSUE;
               if (g_src) dg_d = sat_inc(dg_q);
               else       ig_d = sat_inc(ig_q);
            end
         end
         ISSUE: begin
            if (l2_ready) begin
               state_d = WAIT;
               timer_d = '0;
            end
         end
         WAIT: begin
            timer_d = timer_q + 16'd1;
            if (l2_done) begin
               err_d   = 1'b0;
               state_d = RESP;
            end else if (timer_q == T_LAST) begin
               err_d   = 1'b1;
               to_d    = sat_inc(to_q);
               state_d = RESP;
            end
         end
         RESP: begin
            last_d  = src_q;
            mask_d  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         addr_q  <= '0;
         we_q    <= 1'b0;
         src_q   <= 1'b0;
         last_q  <= 1'b1;
         mask_q  <= 1'b0;
         err_q   <= 1'b0;
         timer_q <= '0;
         ig_q    <= '0;
         dg_q    <= '0;
         busy_q  <= '0;
         to_q    <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         we_q    <= we_d;
         src_q   <= src_d;
         last_q  <= last_d;
         mask_q  <= mask_d;
         err_q   <= err_d;
         timer_q <= timer_d;
         ig_q    <= ig_d;
         dg_q    <= dg_d;
         busy_q  <= busy_d;
         to_q    <= to_d;
      end
   end

   assign l2_valid    = (state_q == ISSUE);
   assign l2_we       = we_q;
   assign l2_addr     = addr_q;
   assign l2_src      = src_q;
   assign i_ack       = (state_q == RESP) & ~src_q;
   assign d_ack       = (state_q == RESP) &  src_q;
   assign err         = (state_q == RESP) &  err_q;
   assign i_grants    = ig_q;
   assign d_grants    = dg_q;
   assign busy_cycles = busy_q;
   assign timeouts    = to_q;

endmodule

// File: tb/tb_l2_port_arbiter.sv
// Scoreboard bench for l2_port_arbiter: directed scenarios then random
// traffic, checked against a transaction-level reference model.
module tb_l2_port_arbiter;

   localparam int AW = 26;
   localparam int CW = 8;
   localparam int TO = 4;
   localparam int CMAX = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          i_req = 1'b0;
   logic [AW-1:0] i_addr = '0;
   logic          i_ack;
   logic          d_req = 1'b0;
   logic          d_we = 1'b0;
   logic [AW-1:0] d_addr = '0;
   logic          d_ack;
   logic          err;
   logic          l2_valid;
   logic          l2_we;
   logic [AW-1:0] l2_addr;
   logic          l2_src;
   logic          l2_ready = 1'b0;
   logic          l2_done = 1'b0;
   logic [CW-1:0] i_grants;
   logic [CW-1:0] d_grants;
   logic [CW-1:0] busy_cycles;
   logic [CW-1:0] timeouts;

   l2_port_arbiter #(.ADDR_W(AW), .CNT_W(CW), .TIMEOUT(TO)) dut (
      .clk(clk), .rst_n(rst_n),
      .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_ack(d_ack),
      .err(err),
      .l2_valid(l2_valid), .l2_we(l2_we), .l2_addr(l2_addr),
      .l2_src(l2_src), .l2_ready(l2_ready), .l2_done(l2_done),
      .i_grants(i_grants), .d_grants(d_grants),
      .busy_cycles(busy_cycles), .timeouts(timeouts)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;

   task automatic check(input string nm, input logic [63:0] act,
                        input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   typedef struct {
      bit          src;
      logic [AW-1:0] addr;
      bit          we;
   } iss_t;
   typedef struct {
      bit src;
      bit err;
   } ack_t;

   iss_t iq[$];
   ack_t aq[$];

   // Reference model: who owns the port, and how the transaction ends
   int            m_ph = 0;
   bit            m_last = 1'b1;
   bit            m_mask = 1'b0;
   bit            m_src = 1'b0;
   int            m_wait = 0;
   int            m_ig = 0, m_dg = 0, m_busy = 0, m_to = 0;

   function automatic int sat(input int v);
      return (v >= CMAX) ? CMAX : v + 1;
   endfunction

   always @(negedge clk or negedge rst_n) begin
      bit ei, ed;
      if (!rst_n) begin
         m_ph = 0; m_last = 1'b1; m_mask = 1'b0; m_wait = 0;
         m_ig = 0; m_dg = 0; m_busy = 0; m_to = 0;
         iq.delete();
         aq.delete();
      end else begin
         if (m_ph != 0) m_busy = sat(m_busy);
         case (m_ph)
            0: begin
               ei = i_req && !(m_mask && !m_last);
               ed = d_req && !(m_mask && m_last);
               m_mask = 1'b0;
               if (ei || ed) begin
                  m_src = (ei && ed) ? !m_last : ed;
                  if (m_src) begin
                     iq.push_back('{1'b1, d_addr, d_we});
                     m_dg = sat(m_dg);
                  end else begin
                     iq.push_back('{1'b0, i_addr, 1'b0});
                     m_ig = sat(m_ig);
                  end
                  m_ph = 1;
               end
            end
            1: if (l2_ready) begin m_ph = 2; m_wait = 0; end
            2: begin
               m_wait++;
               if (l2_done) begin
                  aq.push_back('{m_src, 1'b0});
                  m_ph = 3;
               end else if (m_wait == TO) begin
                  aq.push_back('{m_src, 1'b1});
                  m_to = sat(m_to);
                  m_ph = 3;
               end
            end
            default: begin m_last = m_src; m_mask = 1'b1; m_ph = 0; end
         endcase
      end
   end

   bit   pv = 1'b0;
   iss_t hold;
   int   vcyc = 0;
   int   nissue = 0;

   always @(negedge clk) begin
      iss_t e;
      ack_t a;
      if (!rst_n) begin
         pv = 1'b0;
      end else begin
         if (l2_valid) begin
            vcyc++;
            if (!pv) begin
               nissue++;
               hold = '{l2_src, l2_addr, l2_we};
               if (iq.size() == 0) begin
                  total++; bad++;
                  $display("FAIL issue_unexpected: got addr %0h none expected", l2_addr);
               end else begin
                  e = iq.pop_front();
                  check("issue_src", l2_src, e.src);
                  check("issue_addr", l2_addr, e.addr);
                  check("issue_we", l2_we, e.we);
               end
            end else begin
               check("issue_stable_addr", l2_addr, hold.addr);
               check("issue_stable_src", {l2_src, l2_we}, {hold.src, hold.we});
            end
         end
         pv = l2_valid;
         if (i_ack || d_ack) begin
            check("ack_onehot", i_ack & d_ack, 0);
            if (aq.size() == 0) begin
               total++; bad++;
               $display("FAIL ack_unexpected: got ack src %0d none expected", d_ack);
            end else begin
               a = aq.pop_front();
               check("ack_src", d_ack, a.src);
               check("ack_err", err, a.err);
            end
         end else begin
            check("err_no_ack", err, 0);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Called in the grant cycle; rdly = ISSUE cycles with ready low,
   // ddly = WAIT cycle index carrying l2_done (<0: never)
   task automatic txn(input bit s, input logic [AW-1:0] a, input bit w,
                      input int rdly, input int ddly, input bit keep);
      bit e;
      int nw;
      e  = (ddly < 0) || (ddly >= TO);
      nw = e ? TO : ddly + 1;
      if (s) begin d_req = 1'b1; d_addr = a; d_we = w; end
      else   begin i_req = 1'b1; i_addr = a; end
      l2_ready = (rdly == 0);
      l2_done  = 1'b0;
      step();
      for (int k = 1; k <= rdly; k++) begin
         step();
         l2_ready = (k == rdly);
      end
      step();
      l2_ready = 1'b0;
      l2_done  = (ddly == 0);
      for (int j = 1; j < nw; j++) begin
         step();
         l2_done = (j == ddly);
      end
      step();
      l2_done = 1'b0;
      @(negedge clk);
      check("txn_ack", s ? d_ack : i_ack, 1);
      check("txn_other_ack", s ? i_ack : d_ack, 0);
      check("txn_err", err, e);
      step();
      if (!keep) begin
         if (s) d_req = 1'b0;
         else   i_req = 1'b0;
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_valid", l2_valid, 0);
      check("rst_acks", {i_ack, d_ack, err}, 0);
      check("rst_addr", l2_addr, 0);
      check("rst_src_we", {l2_src, l2_we}, 0);
      check("rst_ig", i_grants, 0);
      check("rst_dg", d_grants, 0);
      check("rst_busy", busy_cycles, 0);
      check("rst_to", timeouts, 0);
      step();

      // single instruction fill, then hold req into the masked cycle
      txn(1'b0, 26'h0ABCDEF, 1'b0, 0, 1, 1'b1);
      @(negedge clk);
      check("t1_ack_pulse", i_ack, 0);
      check("t1_igrants", i_grants, 1);
      check("t1_busy", busy_cycles, 4);
      step();
      @(negedge clk);
      check("mask_no_regrant", l2_valid, 0);
      txn(1'b0, 26'h0ABCDEF, 1'b0, 0, 2, 1'b0);
      check("mask_regrant", i_grants, 2);

      // back-pressure on a data writeback
      vcyc = 0;
      nissue = 0;
      txn(1'b1, 26'h1234567, 1'b1, 5, 0, 1'b0);
      check("bp_valid_cycles", vcyc, 6);
      check("bp_issues", nissue, 1);

      // timeout, then done on the exact timeout cycle
      txn(1'b0, 26'h0000040, 1'b0, 0, -1, 1'b0);
      check("to_count", timeouts, 1);
      txn(1'b1, 26'h3FFFFFF, 1'b0, 1, TO - 1, 1'b0);
      check("to_edge_count", timeouts, 1);
      check("dg_after_dir", d_grants, 2);

      // alternation under continuous contention
      i_req = 1'b1; i_addr = 26'h0000111;
      d_req = 1'b1; d_addr = 26'h0000222; d_we = 1'b0;
      l2_ready = 1'b1; l2_done = 1'b1;
      for (int c = 0; c < 40 && (i_grants + d_grants) < 9; c++) step();
      i_req = 1'b0; d_req = 1'b0;
      @(negedge clk);
      check("alt_igrants", i_grants, 5);
      check("alt_dgrants", d_grants, 4);
      repeat (8) step();

      // reset in the middle of WAIT
      d_req = 1'b1; d_addr = 26'h0055AA5; d_we = 1'b1;
      l2_ready = 1'b1; l2_done = 1'b0;
      step();
      step();
      l2_ready = 1'b0;
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("mrst_valid", l2_valid, 0);
      check("mrst_ack", {i_ack, d_ack, err}, 0);
      check("mrst_counts", {i_grants, d_grants, busy_cycles, timeouts}, 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      i_req = 1'b1; i_addr = 26'h0001234;
      d_req = 1'b1; d_addr = 26'h0004321; d_we = 1'b0;
      step();
      @(negedge clk);
      check("mrst_tie_valid", l2_valid, 1);
      check("mrst_tie_src", l2_src, 0);

      // random traffic
      for (int c = 0; c < 4000; c++) begin
         bit ai, ad;
         @(negedge clk);
         ai = i_ack;
         ad = d_ack;
         step();
         if (i_req) begin
            if (ai) begin
               i_req  = 1'($urandom_range(0, 1));
               i_addr = AW'($urandom);
            end
         end else if ($urandom_range(0, 2) == 0) begin
            i_req  = 1'b1;
            i_addr = AW'($urandom);
         end
         if (d_req) begin
            if (ad) begin
               d_req  = 1'($urandom_range(0, 1));
               d_addr = AW'($urandom);
               d_we   = 1'($urandom_range(0, 1));
            end
         end else if ($urandom_range(0, 2) == 0) begin
            d_req  = 1'b1;
            d_addr = AW'($urandom);
            d_we   = 1'($urandom_range(0, 1));
         end
         l2_ready = 1'($urandom_range(0, 1));
         l2_done  = ($urandom_range(0, 2) == 0);
      end

      // drain outstanding requests
      for (int c = 0; c < 300 && (i_req || d_req); c++) begin
         bit ai, ad;
         @(negedge clk);
         ai = i_ack;
         ad = d_ack;
         step();
         if (ai) i_req = 1'b0;
         if (ad) d_req = 1'b0;
         l2_ready = 1'b1;
         l2_done  = 1'($urandom_range(0, 1));
      end
      check("drain_done", {i_req, d_req}, 0);
      l2_done = 1'b0;
      repeat (10) step();
      @(negedge clk);
      check("end_issue_q", iq.size(), 0);
      check("end_ack_q", aq.size(), 0);
      check("end_igrants", i_grants, m_ig);
      check("end_dgrants", d_grants, m_dg);
      check("end_busy", busy_cycles, m_busy);
      check("end_timeouts", timeouts, m_to);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/l2_port_arbiter.md
Name: l2_port_arbiter

Overview:
- Shares the single next-level (L2) line-fill port between the instruction-cache miss path and the data-cache miss/writeback path.
- Arbitrates round-robin and sequences one outstanding L2 transaction at a time with a valid/ready issue and done completion.
- Returns a one-cycle ack, with an error flag on timeout, to the owning requester.
- Keeps grant, busy and timeout statistics for the statistics module.

Parameters:
- ADDR_W, 26, line-address width (address bits [31:6]).
- CNT_W, 32, statistics counter width.
- TIMEOUT, 255, maximum WAIT cycles before abort; legal range 1..65535.

Ports:
- clk  input  1  clock; all state changes on posedge.
- rst_n  input  1  asynchronous, active-low reset.
- i_req  input  1  instruction-cache fill request (level).
- i_addr  input  ADDR_W  instruction line address.
- i_ack  output  1  one-cycle completion pulse to the instruction cache.
- d_req  input  1  data-cache request (level).
- d_we  input  1  1 = writeback, 0 = fill.
- d_addr  input  ADDR_W  data line address.
- d_ack  output  1  one-cycle completion pulse to the data cache.
- err  output  1  valid with an ack; 1 = transaction timed out.
- l2_valid  output  1  L2 request valid.
- l2_we  output  1  L2 write enable.
- l2_addr  output  ADDR_W  L2 line address.
- l2_src  output  1  0 = instruction, 1 = data.
- l2_ready  input  1  L2 accepts request.
- l2_done  input  1  L2 transaction complete.
- i_grants  output  CNT_W  instruction grants.
- d_grants  output  CNT_W  data grants.
- busy_cycles  output  CNT_W  cycles with state != IDLE.
- timeouts  output  CNT_W  timed-out transactions.

Behaviour:
- Reset (rst_n=0, any time, including mid-transaction): all outputs and counters 0; state IDLE; latched address/we/src 0; last_src=1 (data), so instruction wins the first tie; timer 0; mask cleared. The in-flight transaction is dropped with no ack.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: compute eff_i = i_req & ~(mask & last_src==0) and eff_d = d_req & ~(mask & last_src==1).
  - If exactly one is asserted, grant it. If both, grant the source != last_src.
  - Grant latches addr, we and src (we forced to 0 for instruction), increments that grant counter, and moves to ISSUE.
  - No effective request: stay IDLE. The mask clears after any IDLE cycle.
- ISSUE: l2_valid=1 with the latched l2_addr/l2_we/l2_src, held stable until l2_ready. On l2_ready the state moves to WAIT and the timer is cleared.
- WAIT: l2_valid=0. The timer increments each cycle.
  - l2_done=1 moves to RESP with err_next=0.
  - Otherwise timer==TIMEOUT-1 moves to RESP with err_next=1 and increments timeouts.
  - l2_done has priority over timeout in the same cycle. l2_done is ignored in every state other than WAIT.
- RESP (one cycle): the owner's ack=1 and err=err_next; the other ack stays 0. last_src is set to the owner, mask is set, and the state moves to IDLE.
- Owner mask: in the first IDLE cycle after RESP, the just-served requester's req is ignored. This gives a registered requester one cycle to drop req.
- Requesters hold req and addr until ack. Deasserting req after grant does not cancel the transaction; the ack still pulses.
- Outside RESP, i_ack=d_ack=err=0.
- Latency: grant in cycle N (IDLE). l2_valid at N+1. With l2_ready at N+1 and l2_done at N+2, ack is at N+3. The minimum request-to-ack time is 3 cycles.
- Counters saturate at all-ones and never wrap. busy_cycles increments in every ISSUE/WAIT/RESP cycle.
- Outputs are registered; no combinational path from inputs to l2_* or ack.

Test Plan:
- Single instruction request: i_req=1, i_addr=26'h0ABCDEF, l2_ready same cycle as valid, l2_done 2 cycles later. Required: l2_addr=26'h0ABCDEF, l2_src=0, l2_we=0; i_ack is a single pulse 4 cycles after grant; i_grants=1; busy_cycles=4.
- Simultaneous requests held continuously: grants alternate I, D, I, D. After 4 transactions i_grants=2 and d_grants=2, and no requester is served twice in a row.
- Back-pressure: l2_ready low for 5 cycles. Required: l2_valid and l2_addr stable for all 6 ISSUE cycles; exactly one transaction is accepted.
- Timeout with TIMEOUT=4: l2_done never asserted. Required: ack with err=1 after 4 WAIT cycles and timeouts=1. Then l2_done=1 on the exact timeout cycle: err=0 and timeouts unchanged.
- Owner mask: i_req stays high one cycle after i_ack with d_req=0. Required: no regrant in the masked IDLE cycle; regrant the following cycle.
- Reset mid-WAIT: rst_n pulsed low asynchronously. Required: immediately l2_valid=0, counters=0, no ack. The next i_req/d_req tie grants instruction first.
